lzy_vm_param: RTL and testbench
===============================

# lzy_vm_param

Parametrised vending-machine controller, next generation of the team's fixed-price two-coin FSM. Price, coin values and credit ceiling are parameters. Behaviour beyond the fixed-price FSM:
- coin rejection on overflow or collision;
- customer cancel/refund;
- serialized change return, one unit per cycle.

It sits between the coin-acceptor pulse logic and the dispense/change-hopper drivers. The credit value also feeds the 7-segment display path.

## Interface
- `CW`, 4: credit register width in bits.
- `PRICE`, 4: item price in units. Requires 1 ≤ PRICE ≤ CREDIT_MAX.
- `COIN_A`, 1: value of coin A in units. Requires ≥ 1.
- `COIN_B`, 5: value of coin B in units. Requires ≥ 1.
- `CREDIT_MAX`, 7: maximum credit the machine will hold. Requires CREDIT_MAX < 2^CW.

- `Clk`  in  1  system clock; all state changes on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Coin`  in  2  one-cycle coin pulses, sampled at the rising edge of Clk. Bit 0 = coin A, bit 1 = coin B.
- `Cancel`  in  1  one-cycle refund request, sampled at the rising edge of Clk.
- `Credit`  out  CW  current credit in units.
- `Vend`  out  1  dispense strobe; high exactly one cycle per item.
- `Change`  out  1  change strobe; one unit returned per high cycle.
- `Reject`  out  1  one-cycle pulse; the coin sampled on the previous edge was refused.
- `Busy`  out  1  high while in VEND or CHANGE.

## Operation
- States: IDLE, VEND, CHANGE. Binary encoding in a state register.
- Outputs decoded from registered state (Moore style):
  - `Vend` = (state == VEND).
  - `Change` = (state == CHANGE).
  - `Busy` = (state != IDLE).
- `Credit` and `Reject` are registers.
- IDLE, per edge, first matching rule applies:
  - Cancel = 1:
    - Any coin sampled on the same edge is rejected.
    - If Credit > 0, go to CHANGE; otherwise stay in IDLE.
  - Coin = 2'b11: both coins rejected; Credit unchanged.
  - Exactly one coin bit set: compute sum = Credit + coin value at CW+1 bits.
    - If sum > CREDIT_MAX: reject; Credit unchanged.
    - Otherwise Credit ← sum.
    - If sum ≥ PRICE, go to VEND.
- VEND (one cycle):
  - Credit ← Credit − PRICE.
  - Next state is CHANGE if the result is > 0, otherwise IDLE.
- CHANGE:
  - Credit ← Credit − 1 per edge.
  - Return to IDLE on the edge where Credit goes 1→0.
  - Number of Change cycles equals the credit held on entry.
- Any coin sampled while Busy is rejected and Credit is unchanged. Cancel is ignored while Busy.
- `Reject` ← 1 on any edge that rejects a coin, otherwise 0. Multiple coins rejected on one edge still give a single pulse.
- Invariant: Credit < PRICE whenever state is IDLE.

## Timing
- Reset high: immediately, without waiting for Clk:
  - state = IDLE, Credit = 0, Reject = 0;
  - hence Vend = Change = Busy = 0.
  - Reset mid-VEND or mid-CHANGE abandons the credit; no refund.
- First edge with Reset low operates normally.
- Coin accepted at edge k: Credit shows the new value after k.
  - If the price is reached, Vend is high in cycle k→k+1.
  - Credit drops by PRICE at edge k+1.
  - Change pulses follow back-to-back from cycle k+1.
- Latency from price-reaching coin to Vend: 1 edge.
- Worst-case Busy duration: 1 + (CREDIT_MAX − PRICE) cycles.
- Reject is high for the cycle following the rejecting edge.
- Cancel at edge k with Credit = n > 0: Change is high for cycles k..k+n−1; Busy falls after edge k+n.

## Test plan
1. Reset, then coin A on 4 consecutive edges:
   - Credit 1, 2, 3, 4.
   - Vend high one cycle; Credit returns to 0.
   - Change never asserted; Busy high one cycle.
2. From Credit 0, coin B:
   - Credit 5, Vend one cycle, Credit 1.
   - Change one cycle, Credit 0, back to IDLE.
3. Coin A ×3 (Credit 3), then coin B:
   - 8 > 7, so Reject pulses once and Credit stays 3.
   - Then Cancel: three Change cycles, Credit 2, 1, 0.
4. Coin = 2'b11 in IDLE: Reject pulses, Credit unchanged.
   - Coin A during a CHANGE cycle: Reject pulses, refund count unaffected.
5. Cancel at Credit 0: no state change, no outputs.
   - Cancel together with coin A at Credit 2: Reject pulses, two Change cycles.
6. Reset asserted mid-CHANGE, between clock edges:
   - Change, Busy and Credit go to 0 immediately.
   - After release, coin B vends normally with one change unit.

Source files
------------

// File: rtl/lzy_vm_param.sv
// Parametrised vending-machine controller: coin accumulation with overflow/collision rejection,
// customer refund and one-unit-per-cycle serialized change return.
module lzy_vm_param #(
   parameter int unsigned CW         = 4,
   parameter int unsigned PRICE      = 4,
   parameter int unsigned COIN_A     = 1,
   parameter int unsigned COIN_B     = 5,
   parameter int unsigned CREDIT_MAX = 7
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic [1:0]    Coin,
   input  logic          Cancel,
   output logic [CW-1:0] Credit,
   output logic          Vend,
   output logic          Change,
   output logic          Reject,
   output logic          Busy
);

   typedef enum logic [1:0] {StIdle, StVend, StChange} state_e;

   localparam logic [CW:0]   CoinAW = (CW+1)'(COIN_A);
   localparam logic [CW:0]   CoinBW = (CW+1)'(COIN_B);
   localparam logic [CW:0]   MaxW   = (CW+1)'(CREDIT_MAX);
   localparam logic [CW:0]   PriceX = (CW+1)'(PRICE);
   localparam logic [CW-1:0] PriceW = CW'(PRICE);

   state_e        state_q, state_d;
   logic [CW-1:0] credit_q, credit_d;
   logic          reject_q, reject_d;

   logic [CW:0]   coin_val;
   logic [CW:0]   sum;
   logic [CW-1:0] vend_rem;

   // One extra bit on the sum so an overflowing coin cannot wrap below the ceiling.
   assign coin_val = Coin[0] ? CoinAW : CoinBW;
   assign sum      = {1'b0, credit_q} + coin_val;
   assign vend_rem = credit_q - PriceW;

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      reject_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (Cancel) begin
               reject_d = |Coin;
               if (credit_q != '0) state_d = StChange;
            end else if (Coin == 2'b11) begin
               reject_d = 1'b1;
            end else if (Coin != 2'b00) begin
               if (sum > MaxW) begin
                  reject_d = 1'b1;
               end else begin
                  credit_d = sum[CW-1:0];
                  if (sum >= PriceX) state_d = StVend;
               end
            end
         end
         StVend: begin
            reject_d = |Coin;
            credit_d = vend_rem;
            state_d  = (vend_rem != '0) ? StChange : StIdle;
         end
         StChange: begin
            reject_d = |Coin;
            credit_d = credit_q - 1'b1;
            if (credit_q == CW'(1)) state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= StIdle;
         credit_q <= '0;
         reject_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         reject_q <= reject_d;
      end
   end

   assign Credit = credit_q;
   assign Reject = reject_q;
   assign Vend   = (state_q == StVend);
   assign Change = (state_q == StChange);
   assign Busy   = (state_q != StIdle);

endmodule

// File: tb/tb_lzy_vm_param.sv
// Self-checking bench for lzy_vm_param with default parameters (price 4, coins 1/5, ceiling 7).
module tb_lzy_vm_param;

   logic       Clk;
   logic       Reset;
   logic [1:0] Coin;
   logic       Cancel;
   logic [3:0] Credit;
   logic       Vend;
   logic       Change;
   logic       Reject;
   logic       Busy;

   typedef struct {
      string      tag;
      logic [3:0] credit;
      logic       vend;
      logic       change;
      logic       reject;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   lzy_vm_param dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .Coin   (Coin),
      .Cancel (Cancel),
      .Credit (Credit),
      .Vend   (Vend),
      .Change (Change),
      .Reject (Reject),
      .Busy   (Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input exp_t e);
      check_eq({e.tag, ".credit"}, int'(Credit), int'(e.credit));
      check_eq({e.tag, ".vend"},   int'(Vend),   int'(e.vend));
      check_eq({e.tag, ".change"}, int'(Change), int'(e.change));
      check_eq({e.tag, ".reject"}, int'(Reject), int'(e.reject));
      check_eq({e.tag, ".busy"},   int'(Busy),   int'(e.busy));
   endtask

   // Drive one edge's inputs, queue the outputs expected after that edge, then compare.
   task automatic step(input string tag, input logic [1:0] coin, input logic cancel,
                       input int cr, input logic v, input logic ch, input logic rj,
                       input logic bz);
      exp_t e;
      @(negedge Clk);
      Coin   = coin;
      Cancel = cancel;
      e.tag = tag; e.credit = 4'(cr); e.vend = v; e.change = ch; e.reject = rj; e.busy = bz;
      exp_q.push_back(e);
      @(posedge Clk);
      #1;
      Coin   = 2'b00;
      Cancel = 1'b0;
      check_outputs(exp_q.pop_front());
   endtask

   initial begin
      exp_t e;
      Reset  = 1'b1;
      Coin   = 2'b00;
      Cancel = 1'b0;
      #3;
      e.tag = "reset"; e.credit = 0; e.vend = 0; e.change = 0; e.reject = 0; e.busy = 0;
      check_outputs(e);
      @(negedge Clk);
      Reset = 1'b0;

      // Four A coins reach the price exactly.
      step("t1_a1", 2'b01, 0, 1, 0, 0, 0, 0);
      step("t1_a2", 2'b01, 0, 2, 0, 0, 0, 0);
      step("t1_a3", 2'b01, 0, 3, 0, 0, 0, 0);
      step("t1_a4", 2'b01, 0, 4, 1, 0, 0, 1);
      step("t1_v",  2'b00, 0, 0, 0, 0, 0, 0);
      step("t1_id", 2'b00, 0, 0, 0, 0, 0, 0);

      // Coin B overshoots by one: vend then one change unit; coin during VEND is refused.
      step("t2_b",  2'b10, 0, 5, 1, 0, 0, 1);
      step("t2_v",  2'b01, 0, 1, 0, 1, 1, 1);
      step("t2_c",  2'b00, 0, 0, 0, 0, 0, 0);

      // Overflow rejection, then refund of 3.
      step("t3_a1", 2'b01, 0, 1, 0, 0, 0, 0);
      step("t3_a2", 2'b01, 0, 2, 0, 0, 0, 0);
      step("t3_a3", 2'b01, 0, 3, 0, 0, 0, 0);
      step("t3_ovf", 2'b10, 0, 3, 0, 0, 1, 0);
      step("t3_rj0", 2'b00, 0, 3, 0, 0, 0, 0);
      step("t3_cxl", 2'b00, 1, 3, 0, 1, 0, 1);
      step("t3_c1", 2'b00, 0, 2, 0, 1, 0, 1);
      step("t3_c2", 2'b00, 0, 1, 0, 1, 0, 1);
      step("t3_c3", 2'b00, 0, 0, 0, 0, 0, 0);

      // Collision rejection, then a coin during CHANGE.
      step("t4_a1", 2'b01, 0, 1, 0, 0, 0, 0);
      step("t4_both", 2'b11, 0, 1, 0, 0, 1, 0);
      step("t4_a2", 2'b01, 0, 2, 0, 0, 0, 0);
      step("t4_cxl", 2'b00, 1, 2, 0, 1, 0, 1);
      step("t4_busy", 2'b01, 0, 1, 0, 1, 1, 1);
      step("t4_c2", 2'b00, 0, 0, 0, 0, 0, 0);

      // Cancel with zero credit, then cancel together with a coin.
      step("t5_cx0", 2'b00, 1, 0, 0, 0, 0, 0);
      step("t5_a1", 2'b01, 0, 1, 0, 0, 0, 0);
      step("t5_a2", 2'b01, 0, 2, 0, 0, 0, 0);
      step("t5_cxa", 2'b01, 1, 2, 0, 1, 1, 1);
      step("t5_c1", 2'b00, 0, 1, 0, 1, 0, 1);
      step("t5_c2", 2'b00, 0, 0, 0, 0, 0, 0);

      // Asynchronous reset in the middle of a CHANGE cycle.
      step("t6_a1", 2'b01, 0, 1, 0, 0, 0, 0);
      step("t6_a2", 2'b01, 0, 2, 0, 0, 0, 0);
      step("t6_cxl", 2'b00, 1, 2, 0, 1, 0, 1);
      #1;
      Reset = 1'b1;
      #2;
      e.tag = "t6_rst"; e.credit = 0; e.vend = 0; e.change = 0; e.reject = 0; e.busy = 0;
      check_outputs(e);
      @(negedge Clk);
      Reset = 1'b0;
      step("t6_b",  2'b10, 0, 5, 1, 0, 0, 1);
      step("t6_v",  2'b00, 0, 1, 0, 1, 0, 1);
      step("t6_c",  2'b00, 0, 0, 0, 0, 0, 0);

      check_eq("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
